// File: rtl/alu_result_fifo.sv
// Result buffer behind the 4-bit ALU: a first-word-fall-through FIFO of {sel, result, carry}
// entries tagged with zero/negative/illegal-op flags, drained over a valid/ready handshake.
module alu_result_fifo #(
  parameter int DATA_W = 4,
  parameter int SEL_W  = 3,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [DATA_W-1:0]        in_result,
  input  logic                     in_carry,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SEL_W-1:0]         out_sel,
  output logic [DATA_W-1:0]        out_result,
  output logic                     out_carry,
  output logic                     out_zero,
  output logic                     out_neg,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_illegal,
  input  logic                     clr_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] result;
    logic              carry;
    logic              zero;
    logic              neg;
    logic              illegal;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_err;

  logic   w_wr_en;
  logic   w_rd_en;
  entry_t w_new;
  entry_t w_head;

  // Handshake status comes from the registered count only, so there is no
  // combinational path from in_valid/out_ready back to in_ready/out_valid.
  assign in_ready  = (r_count != CNT_W'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_wr_en   = in_valid & in_ready;
  assign w_rd_en   = out_valid & out_ready;

  always_comb begin
    w_new.sel     = in_sel;
    w_new.result  = in_result;
    w_new.carry   = in_carry;
    w_new.zero    = (in_result == '0);
    w_new.neg     = in_result[DATA_W-1];
    w_new.illegal = (in_sel > SEL_W'(4));
  end

  // NOTE: storage carries no reset; every read is qualified by count, so stale
  // contents are never visible and the array can map onto plain registers/RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_new;
  end

  // NOTE: state is updated with non-blocking assignments so every register sees
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      // An illegal write on the same edge as clr_err keeps the flag set.
      if (w_wr_en && w_new.illegal) r_err <= 1'b1;
      else if (clr_err)             r_err <= 1'b0;
    end
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign count       = r_count;
  assign err_illegal = r_err;

  // NOTE: every output gets a default before the conditional, so no latch is inferred.
  always_comb begin
    out_sel     = '0;
    out_result  = '0;
    out_carry   = 1'b0;
    out_zero    = 1'b0;
    out_neg     = 1'b0;
    out_illegal = 1'b0;
    if (out_valid) begin
      out_sel     = w_head.sel;
      out_result  = w_head.result;
      out_carry   = w_head.carry;
      out_zero    = w_head.zero;
      out_neg     = w_head.neg;
      out_illegal = w_head.illegal;
    end
  end

endmodule
